// File: rtl/toggle_activity_counter_pkg.sv
// -----------------------------------------------------------------------------
// toggle_activity_pkg
// Shared definitions for the toggle activity monitor:
//   - state_t     : controller state encoding (IDLE / MEASURE / DUMP)
//   - DEF_*       : default parameter values for the top level
//   - sat_inc()   : saturating increment for counters up to 32 bits wide
// -----------------------------------------------------------------------------
package toggle_activity_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DUMP    = 2'd2
  } state_t;

  localparam int DEF_N_SIG    = 4;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_WIN_W    = 16;
  localparam int DEF_WEIGHT_W = 8;

  // Increment val by one unless it already holds the all-ones value of a
  // width-bit counter. Callers zero-extend into and truncate out of 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/toggle_activity_counter_cell.sv
// -----------------------------------------------------------------------------
// toggle_cell
// Per-signal edge detector and saturating toggle counter.
//   clk, rst : clock, asynchronous active-high reset
//   load     : start of a measurement; captures sig into prev, clears count
//   en       : sampling cycle; counts sig != prev and updates prev
//   sig      : monitored signal
//   toggle   : sig ^ prev this cycle (only with ENERGY_ACC_EN)
//   count    : number of toggles seen, saturating at all-ones
// Optional feature macro: ENERGY_ACC_EN (exports the toggle strobe).
// CNT_W must not exceed 32.
// -----------------------------------------------------------------------------
module toggle_cell
  import toggle_activity_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             sig,
`ifdef ENERGY_ACC_EN
  output logic             toggle,
`endif
  output logic [CNT_W-1:0] count
);

  logic prev;
  logic tgl;

  assign tgl = sig ^ prev;

`ifdef ENERGY_ACC_EN
  assign toggle = tgl;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b0;
      count <= '0;
    end else if (load) begin
      prev  <= sig;
      count <= '0;
    end else if (en) begin
      prev <= sig;
      if (tgl) count <= CNT_W'(sat_inc(32'(count), CNT_W));
    end
  end

endmodule

// File: rtl/toggle_activity_counter.sv
// -----------------------------------------------------------------------------
// toggle_activity_counter
// Counts 0->1 and 1->0 transitions on each of N_SIG signals over a window of
// win_len clock cycles, then streams the per-signal counts out over a
// valid/ready port, one word per signal, index 0 first.
//   clk, rst          : clock, asynchronous active-high reset
//   start, win_len    : begin a measurement (IDLE only), window length
//   sig_in            : monitored signals
//   cap_w             : per-signal weights, slice i = signal i (ENERGY_ACC_EN)
//   busy              : high in MEASURE and DUMP
//   rd_valid/rd_ready : readout handshake
//   rd_idx, rd_count  : index and toggle count of the current word
//   rd_last           : current word is for index N_SIG-1
//   done              : one-cycle pulse after the final readout handshake
//   energy            : saturating weighted toggle sum (ENERGY_ACC_EN)
// Optional feature macro: ENERGY_ACC_EN.
//
// state   | meaning
// IDLE    | waiting for start
// MEASURE | sampling sig_in, window counter running down
// DUMP    | presenting counts on the readout port
// -----------------------------------------------------------------------------
module toggle_activity_counter
  import toggle_activity_pkg::*;
#(
  parameter  int N_SIG    = DEF_N_SIG,
  parameter  int CNT_W    = DEF_CNT_W,
  parameter  int WIN_W    = DEF_WIN_W,
  parameter  int WEIGHT_W = DEF_WEIGHT_W,
  localparam int IDX_W    = (N_SIG > 1) ? $clog2(N_SIG) : 1,
  localparam int ENERGY_W = CNT_W + WEIGHT_W + IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIN_W-1:0]          win_len,
  input  logic [N_SIG-1:0]          sig_in,
`ifdef ENERGY_ACC_EN
  input  logic [N_SIG*WEIGHT_W-1:0] cap_w,
  output logic [ENERGY_W-1:0]       energy,
`endif
  output logic                      busy,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [IDX_W-1:0]          rd_idx,
  output logic [CNT_W-1:0]          rd_count,
  output logic                      rd_last,
  output logic                      done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SIG - 1);

  state_t            state;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  counts [N_SIG];
  logic              load;
  logic              en;

  assign load = (state == IDLE) && start;
  assign en   = (state == MEASURE);

`ifdef ENERGY_ACC_EN
  localparam int SUM_W = WEIGHT_W + IDX_W + 1;
  localparam int EXT_W = ENERGY_W + 1;

  logic [N_SIG-1:0]    toggles;
  logic [SUM_W-1:0]    w_sum;
  logic [EXT_W-1:0]    e_ext;
  logic [ENERGY_W-1:0] energy_nxt;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_SIG; i++) begin
      if (toggles[i]) w_sum = w_sum + SUM_W'(cap_w[i*WEIGHT_W +: WEIGHT_W]);
    end
    e_ext      = {1'b0, energy} + EXT_W'(w_sum);
    energy_nxt = e_ext[ENERGY_W] ? '1 : e_ext[ENERGY_W-1:0];
  end
`endif

  for (genvar g = 0; g < N_SIG; g++) begin : g_cell
    toggle_cell #(.CNT_W(CNT_W)) u_cell (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .en     (en),
      .sig    (sig_in[g]),
`ifdef ENERGY_ACC_EN
      .toggle (toggles[g]),
`endif
      .count  (counts[g])
    );
  end

  assign rd_count = counts[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      win_cnt  <= '0;
      rd_idx   <= '0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
`ifdef ENERGY_ACC_EN
      energy   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            win_cnt <= win_len;
            busy    <= 1'b1;
`ifdef ENERGY_ACC_EN
            energy  <= '0;
`endif
            if (win_len == '0) begin
              state    <= DUMP;
              rd_valid <= 1'b1;
              rd_idx   <= '0;
              rd_last  <= (N_SIG == 1);
            end else begin
              state <= MEASURE;
            end
          end
        end
        MEASURE: begin
          win_cnt <= win_cnt - 1'b1;
`ifdef ENERGY_ACC_EN
          energy  <= energy_nxt;
`endif
          // Terminal count: this edge evaluates the last toggle of the window.
          if (win_cnt == WIN_W'(1)) begin
            state    <= DUMP;
            rd_valid <= 1'b1;
            rd_idx   <= '0;
            rd_last  <= (N_SIG == 1);
          end
        end
        DUMP: begin
          if (rd_ready) begin
            if (rd_last) begin
              state    <= IDLE;
              busy     <= 1'b0;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              rd_idx   <= '0;
              done     <= 1'b1;
            end else begin
              rd_idx  <= rd_idx + 1'b1;
              rd_last <= ((rd_idx + 1'b1) == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Directed bench for toggle_activity_counter. Inputs are driven and outputs
// sampled on the falling edge; a second instance with CNT_W=4 shares the
// stimulus and is used for the saturation case.
module tb_toggle_activity_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] win_len;
  logic [3:0]  sig_in;
  logic        rd_ready;

  logic        busy, rd_valid, rd_last, done;
  logic [1:0]  rd_idx;
  logic [15:0] rd_count;

  logic        busy4, rd_valid4, rd_last4, done4;
  logic [1:0]  rd_idx4;
  logic [3:0]  rd_count4;

`ifdef ENERGY_ACC_EN
  logic [31:0] cap_w;
  logic [25:0] energy;
  logic [13:0] energy4;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [3:0]  pat  [0:63];
  logic [15:0] exp  [0:3];
  logic [3:0]  exp4 [0:3];

  always #5 clk = ~clk;

  toggle_activity_counter dut (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .sig_in(sig_in),
`ifdef ENERGY_ACC_EN
    .cap_w(cap_w), .energy(energy),
`endif
    .busy(busy), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_idx(rd_idx),
    .rd_count(rd_count), .rd_last(rd_last), .done(done)
  );

  toggle_activity_counter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .sig_in(sig_in),
`ifdef ENERGY_ACC_EN
    .cap_w(cap_w), .energy(energy4),
`endif
    .busy(busy4), .rd_valid(rd_valid4), .rd_ready(rd_ready), .rd_idx(rd_idx4),
    .rd_count(rd_count4), .rd_last(rd_last4), .done(done4)
  );

  task automatic set_exp(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    exp[0] = a; exp[1] = b; exp[2] = c; exp[3] = d;
    for (int i = 0; i < 4; i++) exp4[i] = (exp[i] > 16'd15) ? 4'd15 : exp[i][3:0];
  endtask

  // Called on a falling edge: start with pat[0], then drive pat[1..w].
  task automatic run_window(input int w);
    start = 1'b1; win_len = 16'(w); sig_in = pat[0];
    @(negedge clk);
    start = 1'b0;
    if (w > 0) begin
      compared++;
      if ({busy, rd_valid} !== 2'b10) begin
        mismatched++;
        $display("FAIL measure_flags: busy/rd_valid=%b want 10", {busy, rd_valid});
      end
    end
    for (int k = 1; k <= w; k++) begin
      sig_in = pat[k];
      @(negedge clk);
    end
  endtask

  // Reads four words with rd_ready=1 and returns in the done cycle.
  task automatic read_all();
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({rd_valid, rd_idx, rd_count, rd_last} !== {1'b1, 2'(i), exp[i], (i == 3)}) begin
        mismatched++;
        $display("FAIL word%0d: valid/idx/count/last=%b/%0d/%0d/%b want 1/%0d/%0d/%b",
                 i, rd_valid, rd_idx, rd_count, rd_last, i, exp[i], (i == 3));
      end
      compared++;
      if ({rd_valid4, rd_idx4, rd_count4} !== {1'b1, 2'(i), exp4[i]}) begin
        mismatched++;
        $display("FAIL word4_%0d: valid/idx/count=%b/%0d/%0d want 1/%0d/%0d",
                 i, rd_valid4, rd_idx4, rd_count4, i, exp4[i]);
      end
      @(negedge clk);
    end
    compared++;
    if ({done, busy, rd_valid} !== 3'b100) begin
      mismatched++;
      $display("FAIL done_cycle: done/busy/rd_valid=%b want 100", {done, busy, rd_valid});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; win_len = '0; sig_in = '0; rd_ready = 1'b1;
`ifdef ENERGY_ACC_EN
    cap_w = {8'd4, 8'd3, 8'd2, 8'd1};
`endif
    repeat (2) @(negedge clk);
    compared++;
    if ({busy, rd_valid, rd_idx, rd_count, rd_last, done} !== 22'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want 0", {busy, rd_valid, rd_idx, rd_count, rd_last, done});
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({busy, rd_valid, done} !== 3'b000) begin
      mismatched++;
      $display("FAIL idle_after_reset: busy/rd_valid/done=%b want 000", {busy, rd_valid, done});
    end
  endtask

  task automatic test_basic();
    pat[0] = 4'b0000;
    for (int k = 1; k <= 10; k++) pat[k] = {3'b000, 1'(k % 2)};
    set_exp(16'd10, 16'd0, 16'd0, 16'd0);
    run_window(10);
    read_all();
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("FAIL done_one_cycle: done=%b want 0", done);
    end
  endtask

  task automatic test_start_edge();
    sig_in = 4'b0000;
    @(negedge clk);
    pat[0] = 4'b0010;
    pat[1] = 4'b0010; pat[2] = 4'b0000; pat[3] = 4'b0000; pat[4] = 4'b0010;
    pat[5] = 4'b0010; pat[6] = 4'b0000; pat[7] = 4'b0000; pat[8] = 4'b0000;
    set_exp(16'd0, 16'd3, 16'd0, 16'd0);
    run_window(8);
    read_all();
  endtask

  task automatic test_saturation();
    pat[0] = 4'b0000;
    for (int k = 1; k <= 40; k++) pat[k] = {1'b0, 1'(k >= 5 && k < 20), 1'b0, 1'(k % 2)};
    set_exp(16'd40, 16'd0, 16'd2, 16'd0);
    run_window(40);
    read_all();
  endtask

  task automatic test_zero_window();
    pat[0] = 4'b1111;
    set_exp(16'd0, 16'd0, 16'd0, 16'd0);
    run_window(0);
    read_all();
  endtask

  task automatic test_stall();
    pat[0] = 4'b0000; pat[1] = 4'b1101; pat[2] = 4'b1100; pat[3] = 4'b1001;
    run_window(3);
    rd_ready = 1'b1;
    for (int i = 0; i < 2; i++) @(negedge clk);
    rd_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      compared++;
      if ({rd_valid, rd_idx, rd_count} !== {1'b1, 2'd2, 16'd2}) begin
        mismatched++;
        $display("FAIL stall%0d: valid/idx/count=%b/%0d/%0d want 1/2/2", c, rd_valid, rd_idx, rd_count);
      end
      start = (c == 2); win_len = 16'd5;
      @(negedge clk);
    end
    start = 1'b0;
    rd_ready = 1'b1;
    compared++;
    if ({rd_idx, rd_count, rd_last} !== {2'd2, 16'd2, 1'b0}) begin
      mismatched++;
      $display("FAIL stall_release: idx/count/last=%0d/%0d/%b want 2/2/0", rd_idx, rd_count, rd_last);
    end
    @(negedge clk);
    compared++;
    if ({rd_idx, rd_count, rd_last} !== {2'd3, 16'd1, 1'b1}) begin
      mismatched++;
      $display("FAIL stall_word3: idx/count/last=%0d/%0d/%b want 3/1/1", rd_idx, rd_count, rd_last);
    end
    @(negedge clk);
    compared++;
    if ({done, busy} !== 2'b10) begin
      mismatched++;
      $display("FAIL stall_done: done/busy=%b want 10", {done, busy});
    end
    @(negedge clk);
    compared++;
    if ({busy, rd_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL start_not_queued: busy/rd_valid=%b want 00", {busy, rd_valid});
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k <= 2; k++) pat[k] = 4'b0000;
    set_exp(16'd0, 16'd0, 16'd0, 16'd0);
    run_window(2);
    read_all();
    pat[0] = 4'b0000; pat[1] = 4'b0010; pat[2] = 4'b0000; pat[3] = 4'b0010;
    set_exp(16'd0, 16'd3, 16'd0, 16'd0);
    run_window(3);
    read_all();
  endtask

`ifdef ENERGY_ACC_EN
  task automatic test_energy();
    pat[0] = 4'b0000;
    for (int k = 1; k <= 5; k++) pat[k] = (k % 2 == 1) ? 4'b1111 : 4'b0000;
    set_exp(16'd5, 16'd5, 16'd5, 16'd5);
    run_window(5);
    compared++;
    if ({energy, energy4} !== {26'd50, 14'd50}) begin
      mismatched++;
      $display("FAIL energy: got %0d/%0d want 50/50", energy, energy4);
    end
    read_all();
    compared++;
    if (energy !== 26'd50) begin
      mismatched++;
      $display("FAIL energy_hold: got %0d want 50", energy);
    end
    @(negedge clk);
    pat[0] = 4'b0000;
    set_exp(16'd0, 16'd0, 16'd0, 16'd0);
    run_window(0);
    compared++;
    if (energy !== 26'd0) begin
      mismatched++;
      $display("FAIL energy_clear: got %0d want 0", energy);
    end
    read_all();
  endtask
`endif

  task automatic test_mid_reset();
    logic saw_activity;
    start = 1'b1; win_len = 16'd10; sig_in = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      sig_in = {3'b000, 1'(k % 2)};
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    compared++;
    if ({busy, rd_valid, rd_idx, rd_count, rd_last, done} !== 22'd0) begin
      mismatched++;
      $display("FAIL mid_reset_outputs: got %h want 0", {busy, rd_valid, rd_idx, rd_count, rd_last, done});
    end
    @(negedge clk);
    rst = 1'b0;
    saw_activity = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (done || busy || rd_valid) saw_activity = 1'b1;
      @(negedge clk);
    end
    compared++;
    if (saw_activity !== 1'b0) begin
      mismatched++;
      $display("FAIL aborted_run: done/busy/rd_valid seen=%b want 0", saw_activity);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_edge();
    test_saturation();
    test_zero_window();
    test_stall();
    test_back_to_back();
`ifdef ENERGY_ACC_EN
    test_energy();
`endif
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
